// File: rtl/plot_sink.sv
// ============================================================================
// Module   : plot_sink
// Purpose  : Pixel-plot responder. Filters, queues and commits plots to the
//            160x120 framebuffer write port, and reports per-frame status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plot_sink #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned X_MAX      = 160,
  parameter int unsigned Y_MAX      = 120,
  parameter logic [7:0]  KEY_COLOUR = 8'b00001001,
  parameter bit          KEY_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [7:0]  colour,
  input  logic        plot,
  output logic        ready,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [14:0] written_cnt,
  output logic [14:0] dropped_cnt
);

  localparam int unsigned     c_aw      = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_depth   = FIFO_DEPTH[c_aw:0];
  localparam logic [c_aw:0]   c_cnt_one = {{c_aw{1'b0}}, 1'b1};
  localparam logic [c_aw-1:0] c_ptr_one = {{(c_aw-1){1'b0}}, 1'b1};
  localparam logic [8:0]      c_x_max   = X_MAX[8:0];
  localparam logic [7:0]      c_y_max   = Y_MAX[7:0];
  localparam logic [14:0]     c_sat     = 15'h7FFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [22:0]     r_fifo [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_aw:0]   r_count, w_count_next;
  logic            r_ready, w_ready_next;
  logic            r_mem_we, w_out_next;
  logic [14:0]     r_mem_addr, r_written, r_dropped, w_y15, w_addr;
  logic [7:0]      r_mem_data;
  logic            w_accept, w_filtered, w_push, w_drop, w_pop, w_wr_done;

  // Filtering decision is taken in the acceptance cycle; rejected plots never occupy a slot.
  assign w_accept   = (r_state == S_ACTIVE) && plot && r_ready && !frame_start;
  assign w_filtered = ({1'b0, x} >= c_x_max) || ({1'b0, y} >= c_y_max) ||
                      (KEY_EN && (colour == KEY_COLOUR));
  assign w_push     = w_accept && !w_filtered;
  assign w_drop     = w_accept && w_filtered;
  assign w_y15      = {8'd0, y};
  assign w_addr     = (w_y15 << 7) + (w_y15 << 5) + {7'd0, x};
  assign w_wr_done  = r_mem_we && mem_ready;
  assign w_pop      = (r_count != '0) && (!r_mem_we || mem_ready);

  always_comb begin
    w_count_next = r_count;
    if (frame_start) begin
      w_count_next = '0;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_cnt_one;
    end
    w_out_next = frame_start ? 1'b0 : (w_pop ? 1'b1 : (r_mem_we && !mem_ready));
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state uses post-edge occupancy so DONE follows the final write directly.
  always_comb begin
    w_state_next = r_state;
    w_ready_next = 1'b1;
    case (r_state)
      S_IDLE:   if (frame_start) w_state_next = S_ACTIVE;
      S_ACTIVE: begin
        if (frame_start)    w_state_next = S_ACTIVE;
        else if (frame_end) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (frame_start)                                 w_state_next = S_ACTIVE;
        else if ((w_count_next == '0) && !w_out_next)    w_state_next = S_DONE;
      end
      S_DONE:   if (frame_start) w_state_next = S_ACTIVE;
      default:  w_state_next = S_IDLE;
    endcase
    case (w_state_next)
      S_ACTIVE: w_ready_next = (w_count_next < c_depth);
      S_DRAIN:  w_ready_next = 1'b0;
      default:  w_ready_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {w_addr, colour};
  end

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b1;
    end else begin
      r_ready <= w_ready_next;
    end
  end

  // Output holding register: reloads only when empty or its write has been taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (frame_start) begin
      r_mem_we <= 1'b0;
    end else if (w_pop) begin
      r_mem_we                 <= 1'b1;
      {r_mem_addr, r_mem_data} <= r_fifo[r_rd_ptr];
    end else if (w_wr_done) begin
      r_mem_we <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      r_written <= '0;
      r_dropped <= '0;
    end else begin
      if (w_wr_done && (r_written != c_sat)) r_written <= r_written + 15'd1;
      if (w_drop && (r_dropped != c_sat))    r_dropped <= r_dropped + 15'd1;
    end
  end

  assign ready       = r_ready;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign written_cnt = r_written;
  assign dropped_cnt = r_dropped;
  assign frame_done  = (r_state == S_DONE);
  assign busy        = (r_state == S_ACTIVE) || (r_state == S_DRAIN) ||
                       (r_count != '0) || r_mem_we;

endmodule

`default_nettype wire
